multicycle_controller: RTL
==========================

Name: multicycle_controller

Overview:
Control FSM that sequences the multicycle RV32I datapath (PC, instruction register, register file, ALU, immediate extender, unified memory). It decodes op/funct fields, walks each instruction through fetch, decode, execute, memory and writeback states, and drives every mux select and write enable. It also supplies ImmSrc to the immediate extender using that block's encoding: 000 I, 001 S, 010 B, 011 U, 100 J.

Parameters:
STATE_W, 4, width of the state register and the StateDbg port.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
op  input  7  Instr[6:0] from the instruction register
funct3  input  3  Instr[14:12]
funct7b5  input  1  Instr[30]
Zero  input  1  ALU zero flag
PCWrite  output  1  PC register enable
AdrSrc  output  1  memory address select: 0 = PC, 1 = ALUOut
MemWrite  output  1  memory write strobe
IRWrite  output  1  instruction register and OldPC enable
ResultSrc  output  2  result select: 00 ALUOut, 01 Data, 10 ALUResult
ALUSrcA  output  2  ALU A select: 00 PC, 01 OldPC, 10 A reg, 11 zero
ALUSrcB  output  2  ALU B select: 00 WriteData reg, 01 ImmExt, 10 constant 4
ALUControl  output  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt
ImmSrc  output  3  immediate format for the extender
RegWrite  output  1  register file write enable
Illegal  output  1  one-cycle pulse when an unsupported opcode is decoded
StateDbg  output  STATE_W  current state encoding, for visibility only

Behaviour:
- clk and rst_n are the only clock and reset. Reset is asynchronous and active-low.
- While rst_n is low, the state is FETCH. PCWrite, IRWrite, MemWrite, RegWrite and Illegal are forced to 0 combinationally. All other outputs take their FETCH values.
- The first FETCH actions occur on the first rising edge after reset release.
- Outputs are Moore-style decodes of the state, with two exceptions:
  - PCWrite in BEQ depends on Zero.
  - ImmSrc is decoded purely from op.
- ImmSrc decode: lw/addi-class/other → 000; sw → 001; branch → 010; lui → 011; jal → 100.
- States and transitions:
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10, PCWrite=1. Next: DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=01, add (branch/jump target into ALUOut). Next by op:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECUTER
    - 0010011 → EXECUTEI
    - 1100011 → BEQ
    - 1101111 → JAL
    - 0110111 → LUI
    - any other op → FETCH, with Illegal=1 for this cycle and no write enables asserted
  - MEMADR: ALUSrcA=10, ALUSrcB=01, add. Next: MEMREAD if op[5]=0, else MEMWRITE.
  - MEMREAD: AdrSrc=1, ResultSrc=00. Next: MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1. Next: FETCH.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1. Next: FETCH.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, funct decode. Next: ALUWB.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, funct decode. Next: ALUWB.
  - LUI: ALUSrcA=11, ALUSrcB=01, add. Next: ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1. Next: FETCH.
  - BEQ: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00. PCWrite = Zero XOR funct3[0], so both beq and bne are supported. Next: FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1. Next: ALUWB (writes PC+4).
- Funct decode (EXECUTER/EXECUTEI), by funct3:
  - 000: sub if funct7b5 and op[5], else add
  - 010: slt
  - 100: xor
  - 110: or
  - 111: and
  - all other funct3: add
- Any output not listed for a state is 0.
- Unreachable state encodings go to FETCH on the next edge.
- Instruction latency: lw 5 cycles; sw, R-type, I-type, lui and jal 4 cycles; branch 3 cycles.
- Reset asserted mid-instruction (e.g. during MEMWRITE or MEMWB) drops all write enables immediately, and the instruction is abandoned.

Optional Feature:
- Macro: MEM_WAIT_EN.
- When defined:
  - Adds input MemReady (1 bit), placed after Zero.
  - FETCH, MEMREAD and MEMWRITE hold their state, with outputs unchanged, while MemReady=0. They advance only on a cycle with MemReady=1.
  - PCWrite, IRWrite and MemWrite are asserted only in the cycle where MemReady=1, so each has exactly one effective cycle.
- When undefined: no MemReady port; memory is treated as single-cycle, as in the transitions above.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - state enum type (STATE_W bits)
  - opcode constants
  - ImmSrc constants IMM_I/IMM_S/IMM_B/IMM_U/IMM_J
  - ALUControl constants
  - ResultSrc/ALUSrcA/ALUSrcB select constants
- One sub-module, alu_decoder. Inputs: ALUOp (2 bits: 00 add, 01 sub, 10 funct), funct3, funct7b5, op[5]. Output: ALUControl. The FSM drives ALUOp.

Test Plan:
- Reset, then addi x1,x0,2 (Instr 0x00200093): states FETCH→DECODE→EXECUTEI→ALUWB; ImmSrc=000 throughout; ALUControl=000 in EXECUTEI; RegWrite=1 only in cycle 4.
- sw (0x00112023) then lw (0x00012183):
  - sw: ImmSrc=001; MemWrite=1 and AdrSrc=1 in cycle 4 only.
  - lw: 5 cycles; ResultSrc=01 and RegWrite=1 in cycle 5.
- beq with Zero=1, funct3=000: PCWrite=1 in BEQ (cycle 3). bne with Zero=1, funct3=001: PCWrite=0. Both have ImmSrc=010 and return to FETCH after 3 cycles.
- R-type sub (0x40208033): ALUControl=001. slt (funct3=010): ALUControl=101. jal (0x0056786F): ImmSrc=100, PCWrite=1 in JAL, RegWrite=1 in the next cycle.
- Illegal op 0x0000000B: Illegal=1 for one cycle in DECODE, then FETCH; no RegWrite/MemWrite at any point. Separately, rst_n low during MEMWRITE: MemWrite drops the same cycle and StateDbg shows FETCH.
- MEM_WAIT_EN build: MemReady=0 for 3 cycles in FETCH holds the state with PCWrite=IRWrite=0; MemReady=1 gives one-cycle PCWrite/IRWrite, then DECODE.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - shared types and encodings for the multicycle RV32I controller
package riscv_ctrl_pkg;

    localparam int STATE_BITS = 4;

    typedef enum logic [STATE_BITS-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_LUI      = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_AREG  = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_WDATA = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    function automatic logic [2:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_LUI:    return IMM_U;
            OP_JAL:    return IMM_J;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// rtl/multicycle_controller_alu_decoder.sv - maps ALUOp and funct fields to ALUControl
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0] ALUOp,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] ALUControl
);

    always_comb begin
        ALUControl = ALU_ADD;
        if (ALUOp == ALUOP_SUB) begin
            ALUControl = ALU_SUB;
        end else if (ALUOp == ALUOP_FUNCT) begin
            case (funct3)
                // op5 separates R-type sub from addi with bit 30 set in its immediate
                3'b000:  ALUControl = (funct7b5 && op5) ? ALU_SUB : ALU_ADD;
                3'b010:  ALUControl = ALU_SLT;
                3'b100:  ALUControl = ALU_XOR;
                3'b110:  ALUControl = ALU_OR;
                3'b111:  ALUControl = ALU_AND;
                default: ALUControl = ALU_ADD;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle RV32I control FSM; MEM_WAIT_EN adds MemReady handshaking
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [6:0]         op,
    input  logic [2:0]         funct3,
    input  logic               funct7b5,
    input  logic               Zero,
`ifdef MEM_WAIT_EN
    input  logic               MemReady,
`endif
    output logic               PCWrite,
    output logic               AdrSrc,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic [1:0]         ResultSrc,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [2:0]         ALUControl,
    output logic [2:0]         ImmSrc,
    output logic               RegWrite,
    output logic               Illegal,
    output logic [STATE_W-1:0] StateDbg
);

    state_t     state_q, state_d;
    logic       mem_go;
    logic [1:0] alu_op;
    logic       pc_write, mem_write, ir_write, reg_write, illegal_op;

`ifdef MEM_WAIT_EN
    assign mem_go = MemReady;
`else
    assign mem_go = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (mem_go) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECUTER;
                    OP_ITYPE:          state_d = S_EXECUTEI;
                    OP_BRANCH:         state_d = S_BEQ;
                    OP_JAL:            state_d = S_JAL;
                    OP_LUI:            state_d = S_LUI;
                    default:           state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_go) state_d = S_MEMWB;
            S_MEMWRITE: if (mem_go) state_d = S_FETCH;
            S_EXECUTER, S_EXECUTEI, S_LUI, S_JAL: state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        pc_write   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        illegal_op = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_WDATA;
        alu_op     = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                ir_write  = mem_go;
                pc_write  = mem_go;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (op)
                    OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE,
                    OP_BRANCH, OP_JAL, OP_LUI: illegal_op = 1'b0;
                    default:                   illegal_op = 1'b1;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_AREG;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                reg_write = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc    = 1'b1;
                mem_write = mem_go;
            end
            S_EXECUTER: begin
                ALUSrcA = SRCA_AREG;
                alu_op  = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                ALUSrcA = SRCA_AREG;
                ALUSrcB = SRCB_IMM;
                alu_op  = ALUOP_FUNCT;
            end
            S_LUI: begin
                ALUSrcA = SRCA_ZERO;
                ALUSrcB = SRCB_IMM;
            end
            S_ALUWB:    reg_write = 1'b1;
            S_BEQ: begin
                // funct3[0] inverts the sense of Zero, turning beq into bne
                ALUSrcA  = SRCA_AREG;
                alu_op   = ALUOP_SUB;
                pc_write = Zero ^ funct3[0];
            end
            S_JAL: begin
                ALUSrcA  = SRCA_OLDPC;
                ALUSrcB  = SRCB_FOUR;
                pc_write = 1'b1;
            end
            default: ;
        endcase
    end

    alu_decoder u_alu_decoder (
        .ALUOp      (alu_op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .op5        (op[5]),
        .ALUControl (ALUControl)
    );

    // Write enables are masked by reset directly so an abandoned instruction cannot commit
    assign PCWrite  = pc_write   & rst_n;
    assign MemWrite = mem_write  & rst_n;
    assign IRWrite  = ir_write   & rst_n;
    assign RegWrite = reg_write  & rst_n;
    assign Illegal  = illegal_op & rst_n;
    assign ImmSrc   = imm_src_of(op);
    assign StateDbg = STATE_W'(state_q);

endmodule
